// File: rtl/adder_share_ctrl.sv
// Round-robin arbiter time-sharing one registered 32-bit adder across NUM_REQ clients; 2 cycles accept->rsp_valid.
// req_ready asserts only in IDLE, so one op is in flight; rsp_* holds until rsp_ready, max 1 op per 4 cycles.
module adder_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*32-1:0] req_op1,
  input  logic [NUM_REQ*32-1:0] req_op2,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [31:0]          add_op1,
  output logic [31:0]          add_op2,
  input  logic [31:0]          add_result,
  output logic                 rsp_valid,
  output logic [NUM_REQ-1:0]   rsp_id,
  output logic [31:0]          rsp_result,
  input  logic                 rsp_ready,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   grant;
  logic [IDX_W-1:0]     win_idx;
  logic                 found;
  logic [IDX_W:0]       scan;
  logic [IDX_W:0]       nxt;
  logic [31:0]          op1_sel;
  logic [31:0]          op2_sel;

  // Scan starting at rr_ptr and wrapping; the first valid requester wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan >= NREQ) scan = scan - NREQ;
      if (!found && req_valid[scan[IDX_W-1:0]]) begin
        found                      = 1'b1;
        grant[scan[IDX_W-1:0]]     = 1'b1;
        win_idx                    = scan[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    op1_sel = '0;
    op2_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        op1_sel = req_op1[32*i +: 32];
        op2_sel = req_op2[32*i +: 32];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gnt_idx} + 1'b1;
    if (nxt >= NREQ) nxt = '0;
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_idx    <= '0;
      gnt        <= '0;
      add_op1    <= '0;
      add_op2    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            add_op1 <= op1_sel;
            add_op2 <= op2_sel;
            gnt     <= grant;
            gnt_idx <= win_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rsp_result <= add_result;
          rsp_id     <= gnt;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            rr_ptr    <= nxt[IDX_W-1:0];
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized and directed bench for adder_share_ctrl against a round-robin/modulo-sum reference model.
module tb_adder_share_ctrl;
  localparam int N  = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_op1, req_op2;
  logic [N-1:0]    req_ready;
  logic [31:0]     add_op1, add_op2, add_result;
  logic            rsp_valid;
  logic [N-1:0]    rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_ready;
  logic            busy;
  logic [CW-1:0]   op_count;

  int checks = 0;
  int failures = 0;
  int exp_rr = 0;
  int exp_cnt = 0;

  adder_share_ctrl #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .add_op1(add_op1), .add_op2(add_op2), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_ready(rsp_ready),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Shared adder stand-in: registered sum, carry dropped.
  always @(posedge clk) add_result <= add_op1 + add_op2;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr + k) % N;
      if ((v & (N'(1) << i)) != 0) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rr = 0; exp_cnt = 0;
  endtask

  task automatic run_op(input logic [N-1:0] vld, input logic [N*32-1:0] o1, input logic [N*32-1:0] o2,
                        input int hold, output logic [N-1:0] rdy_seen, output int lat,
                        output logic [N-1:0] id, output logic [31:0] res, output logic [CW-1:0] cnt);
    @(negedge clk);
    req_valid = vld; req_op1 = o1; req_op2 = o2; rsp_ready = 1'b0;
    #1 rdy_seen = req_ready;
    @(negedge clk);
    req_valid = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    repeat (hold) @(negedge clk);
    id = rsp_id; res = rsp_result;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cnt = op_count;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_op1 = '0; req_op2 = '0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (op_count !== '0) begin failures++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    checks++; if (add_op1 !== 32'd0 || add_op2 !== 32'd0) begin failures++; $display("FAIL reset_add_ops got=%h/%h exp=0/0", add_op1, add_op2); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || req_ready !== '0) begin failures++; $display("FAIL reset_idle busy=%b req_ready=%b exp=0/00", busy, req_ready); end
  endtask

  task automatic test_single();
    logic [N-1:0] rdy, id; logic [31:0] res; logic [CW-1:0] cnt; int lat;
    run_op(2'b01, {32'd0, 32'd5}, {32'd0, 32'd7}, 0, rdy, lat, id, res, cnt);
    exp_rr = 1; exp_cnt = 1;
    checks++; if (rdy !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", rdy); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", lat); end
    checks++; if (id !== 2'b01 || res !== 32'd12) begin failures++; $display("FAIL single_rsp got=%b/%0d exp=01/12", id, res); end
    checks++; if (cnt !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", cnt); end
    checks++; if (add_op1 !== 32'd5 || add_op2 !== 32'd7) begin failures++; $display("FAIL single_ops_hold got=%0d/%0d exp=5/7", add_op1, add_op2); end
  endtask

  task automatic test_alternate();
    logic [N-1:0] alt_ids [4];
    logic [N-1:0] rdy, id; logic [31:0] res; logic [CW-1:0] cnt; int lat;
    logic [N*32-1:0] o1, o2;
    alt_ids = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      int w;
      o1 = {$urandom, $urandom}; o2 = {$urandom, $urandom};
      run_op(2'b11, o1, o2, 0, rdy, lat, id, res, cnt);
      w = (alt_ids[k] == 2'b01) ? 0 : 1;
      checks++; if (id !== alt_ids[k] || res !== o1[32*w +: 32] + o2[32*w +: 32])
        begin failures++; $display("FAIL alternate_%0d got=%b/%h exp=%b/%h", k, id, res, alt_ids[k], o1[32*w +: 32] + o2[32*w +: 32]); end
      exp_rr = (w + 1) % N; exp_cnt = (exp_cnt + 1) % 16;
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] rdy, id; logic [31:0] res; logic [CW-1:0] cnt; int lat;
    run_op(2'b10, {32'hFFFF_FFFF, 32'd0}, {32'd1, 32'd0}, 0, rdy, lat, id, res, cnt);
    exp_rr = 0; exp_cnt = (exp_cnt + 1) % 16;
    checks++; if (id !== 2'b10 || res !== 32'h0) begin failures++; $display("FAIL wrap_sum got=%b/%h exp=10/00000000", id, res); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] id0; logic [31:0] res0; int t; int bad;
    @(negedge clk);
    req_valid = 2'b01; req_op1 = {32'd0, 32'd100}; req_op2 = {32'd0, 32'd23}; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    t = 0;
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    checks++; if (!rsp_valid) begin failures++; $display("FAIL bp_rsp_timeout got=0 exp=1"); end
    id0 = rsp_id; res0 = rsp_result; bad = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || rsp_result !== res0 || req_ready !== '0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0 || id0 !== 2'b01 || res0 !== 32'd123)
      begin failures++; $display("FAIL bp_hold bad_cycles=%0d id=%b res=%0d exp=0/01/123", bad, id0, res0); end
    req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_rr = 1; exp_cnt = (exp_cnt + 1) % 16;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== CW'(exp_cnt))
      begin failures++; $display("FAIL bp_release busy=%b vld=%b cnt=%0d exp=0/0/%0d", busy, rsp_valid, op_count, exp_cnt); end
  endtask

  task automatic test_reset_midop();
    logic [N-1:0] rdy, id; logic [31:0] res; logic [CW-1:0] cnt; int lat; int seen;
    @(negedge clk);
    req_valid = 2'b01; req_op1 = {32'd0, 32'd9}; req_op2 = {32'd0, 32'd9};
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 || op_count !== '0 || add_op1 !== '0 || busy !== 1'b0)
      begin failures++; $display("FAIL midop_reset vld=%b id=%b res=%h cnt=%0d op1=%h busy=%b exp=all 0", rsp_valid, rsp_id, rsp_result, op_count, add_op1, busy); end
    @(negedge clk);
    reset = 1'b0; exp_rr = 0; exp_cnt = 0; seen = 0;
    repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++; if (seen != 0) begin failures++; $display("FAIL midop_no_rsp got=%0d exp=0", seen); end
    run_op(2'b10, {32'd40, 32'd0}, {32'd2, 32'd0}, 1, rdy, lat, id, res, cnt);
    exp_rr = 0; exp_cnt = 1;
    checks++; if (id !== 2'b10 || res !== 32'd42 || cnt !== 4'd1)
      begin failures++; $display("FAIL midop_after got=%b/%0d/%0d exp=10/42/1", id, res, cnt); end
  endtask

  task automatic test_count_wrap();
    logic [N-1:0] rdy, id; logic [31:0] res; logic [CW-1:0] cnt; int lat;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      run_op(2'b01, {32'd0, 32'(k)}, {32'd0, 32'd1}, 0, rdy, lat, id, res, cnt);
      exp_cnt = k % 16; exp_rr = 1;
      if (k >= 15) begin
        checks++; if (cnt !== CW'(exp_cnt)) begin failures++; $display("FAIL count_wrap_%0d got=%0d exp=%0d", k, cnt, exp_cnt); end
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] rdy, id, vld; logic [31:0] res; logic [CW-1:0] cnt; int lat; int w;
    logic [N*32-1:0] o1, o2;
    for (int k = 0; k < 24; k++) begin
      vld = N'($urandom_range(1, 3));
      o1 = {$urandom, $urandom}; o2 = {$urandom, $urandom};
      run_op(vld, o1, o2, $urandom_range(0, 3), rdy, lat, id, res, cnt);
      w = pick(vld, exp_rr);
      exp_rr = (w + 1) % N; exp_cnt = (exp_cnt + 1) % 16;
      checks++;
      if (rdy !== (N'(1) << w) || lat != 2 || id !== (N'(1) << w) || res !== o1[32*w +: 32] + o2[32*w +: 32] || cnt !== CW'(exp_cnt)) begin
        failures++;
        $display("FAIL random_%0d rdy=%b lat=%0d id=%b res=%h cnt=%0d exp=%b/2/%b/%h/%0d", k, rdy, lat, id, res, cnt,
                 N'(1) << w, N'(1) << w, o1[32*w +: 32] + o2[32*w +: 32], exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_wrap();
    test_backpressure();
    test_reset_midop();
    test_count_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
